// File: rtl/iob_bus_arbiter2.sv
// rtl/iob_bus_arbiter2.sv - two-port IOb native bus arbiter, one transaction in flight
// Registers the winner onto the shared port and routes the response back to its owner.
module iob_bus_arbiter2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s0_valid,
  input  logic [ADDR_W-1:0]   s0_addr,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  output logic                s0_ready,
  output logic [DATA_W-1:0]   s0_rdata,
  input  logic                s1_valid,
  input  logic [ADDR_W-1:0]   s1_addr,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  output logic                s1_ready,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ready,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                grant,
  output logic                busy,
  output logic                err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   winner;
  logic   any_valid;
  logic   done;

  always_comb begin
    any_valid = s0_valid | s1_valid;
    winner    = 1'b0;
    if (s0_valid && s1_valid)
      winner = (RR != 0) ? ~last_grant : 1'b0;
    else
      winner = s1_valid;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = BUSY;
      BUSY:    if (m_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requester fields are captured only on the IDLE->BUSY edge, so they may change freely while BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_valid) begin
        grant      <= winner;
        last_grant <= winner;
        m_addr     <= winner ? s1_addr  : s0_addr;
        m_wdata    <= winner ? s1_wdata : s0_wdata;
        m_wstrb    <= winner ? s1_wstrb : s0_wstrb;
      end
      if (state == IDLE && m_ready)
        err <= 1'b1;
    end
  end

  assign busy     = (state == BUSY);
  assign m_valid  = busy;
  assign done     = busy & m_ready;
  assign s0_ready = done & ~grant;
  assign s1_ready = done &  grant;
  assign s0_rdata = s0_ready ? m_rdata : '0;
  assign s1_rdata = s1_ready ? m_rdata : '0;

endmodule

// File: tb/tb_iob_bus_arbiter2.sv
// tb/tb_iob_bus_arbiter2.sv - directed bench for iob_bus_arbiter2
// A round-robin and a fixed-priority instance share the requester inputs.
module tb_iob_bus_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s1_valid;
  logic [31:0] s0_addr, s1_addr, s0_wdata, s1_wdata;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready_man, zw;

  logic        s0_ready, s1_ready, m_valid, m_ready, grant, busy, err;
  logic [31:0] s0_rdata, s1_rdata, m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  logic        f_s0_ready, f_s1_ready, f_m_valid, f_m_ready, f_grant, f_busy, f_err;
  logic [31:0] f_s0_rdata, f_s1_rdata, f_m_addr, f_m_wdata;
  logic [3:0]  f_m_wstrb;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign m_ready   = zw ? m_valid   : m_ready_man;
  assign f_m_ready = zw ? f_m_valid : m_ready_man;

  iob_bus_arbiter2 #(.ADDR_W(32), .DATA_W(32), .RR(1)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_ready(s0_ready), .s0_rdata(s0_rdata),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_ready(s1_ready), .s1_rdata(s1_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .grant(grant), .busy(busy), .err(err)
  );

  iob_bus_arbiter2 #(.ADDR_W(32), .DATA_W(32), .RR(0)) dut_fp (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_ready(f_s0_ready), .s0_rdata(f_s0_rdata),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_ready(f_s1_ready), .s1_rdata(f_s1_rdata),
    .m_valid(f_m_valid), .m_addr(f_m_addr), .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb),
    .m_ready(f_m_ready), .m_rdata(m_rdata),
    .grant(f_grant), .busy(f_busy), .err(f_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int          c0, c1, idx;
  logic [1:0]  order [4];

  initial begin
    rst = 1'b1; zw = 1'b0; m_ready_man = 1'b0; m_rdata = '0;
    s0_valid = 1'b0; s0_addr = '0; s0_wdata = '0; s0_wstrb = '0;
    s1_valid = 1'b0; s1_addr = '0; s1_wdata = '0; s1_wstrb = '0;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd0; order[3] = 2'd1;
    tick();
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_addr",  m_addr, 32'd0);
    check("rst_grant",   {31'b0, grant}, 32'd0);
    check("rst_busy_err", {30'b0, busy, err}, 32'd0);
    check("rst_ready", {30'b0, s0_ready, s1_ready}, 32'd0);
    rst = 1'b0;

    // single read, zero wait
    s0_valid = 1'b1; s0_addr = 32'h100; s0_wstrb = 4'h0;
    tick();
    check("rd_m_valid", {31'b0, m_valid}, 32'd1);
    check("rd_m_addr",  m_addr, 32'h100);
    check("rd_busy",    {31'b0, busy}, 32'd1);
    m_ready_man = 1'b1; m_rdata = 32'hDEADBEEF;
    #1;
    check("rd_s0_ready", {31'b0, s0_ready}, 32'd1);
    check("rd_s0_rdata", s0_rdata, 32'hDEADBEEF);
    check("rd_s1_ready", {31'b0, s1_ready}, 32'd0);
    check("rd_s1_rdata", s1_rdata, 32'd0);
    s0_valid = 1'b0;
    tick();
    m_ready_man = 1'b0;
    check("rd_done_idle", {30'b0, m_valid, busy}, 32'd0);
    check("rd_rdata_off", s0_rdata, 32'd0);

    // write with 3 wait states
    s1_valid = 1'b1; s1_addr = 32'h204; s1_wdata = 32'h12345678; s1_wstrb = 4'hF;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("wr_wait_valid", {31'b0, m_valid}, 32'd1);
      check("wr_wait_addr",  m_addr, 32'h204);
      check("wr_wait_wdata", m_wdata, 32'h12345678);
      check("wr_wait_wstrb", {28'b0, m_wstrb}, 32'hF);
      check("wr_wait_ready", {30'b0, s0_ready, s1_ready}, 32'd0);
      tick();
    end
    m_ready_man = 1'b1;
    #1;
    check("wr_last_valid", {31'b0, m_valid}, 32'd1);
    check("wr_last_wdata", m_wdata, 32'h12345678);
    check("wr_s1_ready", {30'b0, s0_ready, s1_ready}, 32'd1);
    s1_valid = 1'b0;
    tick();
    m_ready_man = 1'b0;
    check("wr_done_idle", {30'b0, m_valid, s1_ready}, 32'd0);

    // round-robin and fixed priority, continuous requests, zero-wait memory
    do_reset();
    zw = 1'b1; s0_valid = 1'b1; s1_valid = 1'b1;
    c0 = 0; c1 = 0; idx = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i % 2 == 1) begin
        check("rr_ready_pulse", {31'b0, s0_ready ^ s1_ready}, 32'd1);
        if (idx < 4) check("rr_order", {31'b0, s1_ready}, {30'b0, order[idx]});
        idx++;
      end else begin
        check("rr_gap", {30'b0, s0_ready, s1_ready}, 32'd0);
      end
      c0 += int'(s0_ready); c1 += int'(s1_ready);
    end
    check("rr_count0", c0, 32'd2);
    check("rr_count1", c1, 32'd2);

    do_reset();
    c0 = 0; c1 = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      c0 += int'(f_s0_ready); c1 += int'(f_s1_ready);
    end
    check("fp_count0", c0, 32'd4);
    check("fp_count1", c1, 32'd0);
    s0_valid = 1'b0;
    tick();
    check("fp_s1_served", {30'b0, f_s0_ready, f_s1_ready}, 32'd1);
    check("fp_grant", {31'b0, f_grant}, 32'd1);
    s1_valid = 1'b0; zw = 1'b0;
    tick();

    // input change while BUSY
    do_reset();
    s0_valid = 1'b1; s0_addr = 32'h100;
    tick();
    s0_addr = 32'h300;
    tick();
    check("hold_m_addr", m_addr, 32'h100);
    m_ready_man = 1'b1;
    #1;
    check("hold_addr_end", m_addr, 32'h100);
    check("hold_ready", {31'b0, s0_ready}, 32'd1);
    s0_valid = 1'b0;
    tick();
    m_ready_man = 1'b0;

    // spurious m_ready in IDLE
    check("sp_err_before", {31'b0, err}, 32'd0);
    m_ready_man = 1'b1;
    #1;
    check("sp_no_ready", {30'b0, s0_ready, s1_ready}, 32'd0);
    tick();
    m_ready_man = 1'b0;
    check("sp_err_set", {31'b0, err}, 32'd1);
    tick();
    tick();
    check("sp_err_sticky", {30'b0, err, busy}, 32'd2);

    // async reset mid-BUSY
    s1_valid = 1'b1; s1_addr = 32'h44;
    tick();
    check("ab_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ab_cleared", {29'b0, m_valid, busy, err}, 32'd0);
    m_ready_man = 1'b1;
    #1;
    check("ab_no_ready", {30'b0, s0_ready, s1_ready}, 32'd0);
    s1_valid = 1'b0; m_ready_man = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("ab_idle", {31'b0, m_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/iob_bus_arbiter2.md
# iob_bus_arbiter2

Two-requester arbiter that shares one IOb native memory port between the core instruction bus (port 0) and data bus (port 1), e.g. in front of a single-port SRAM or the external-memory bridge. It accepts at most one transaction at a time. It registers the winning request onto the shared port and holds the grant until the memory responds. It then routes the response back to the owning requester. Grant policy is round-robin or fixed priority.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- RR, 1, 1 selects round-robin; 0 selects fixed priority with port 0 winning.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s0_valid, s1_valid  in  1  request; held with its fields until the matching sN_ready.
- s0_addr, s1_addr  in  ADDR_W  byte address.
- s0_wdata, s1_wdata  in  DATA_W  write data.
- s0_wstrb, s1_wstrb  in  DATA_W/8  byte strobes; 0 means read.
- s0_ready, s1_ready  out  1  one-cycle response pulse.
- s0_rdata, s1_rdata  out  DATA_W  read data, valid while sN_ready=1.
- m_valid  out  1  shared-port request.
- m_addr  out  ADDR_W  shared-port address.
- m_wdata  out  DATA_W  shared-port write data.
- m_wstrb  out  DATA_W/8  shared-port strobes.
- m_ready  in  1  memory response pulse.
- m_rdata  in  DATA_W  memory read data.
- grant  out  1  index of the current or last owner.
- busy  out  1  transaction in flight (state BUSY).
- err  out  1  sticky; m_ready seen while IDLE.

## Operation
- FSM states: IDLE, BUSY.
- IDLE:
  - m_valid=0.
  - If s0_valid|s1_valid, choose a winner.
    - Only one valid: that port wins.
    - Both valid with RR=1: the port not equal to last_grant wins.
    - Both valid with RR=0: port 0 wins.
  - At the clock edge: grant←winner; m_addr/m_wdata/m_wstrb←winner fields; last_grant←winner; state←BUSY.
- BUSY:
  - m_valid=1; m_addr, m_wdata and m_wstrb hold the registered values.
  - Requester inputs are not resampled, so changes on them do not affect the shared port.
  - When m_ready=1, in the same cycle (combinational): s[grant]_ready=1 and s[grant]_rdata=m_rdata.
  - The other port's ready=0 and rdata=0.
  - At that clock edge: state←IDLE; m_valid←0.
- sN_rdata=0 whenever sN_ready=0.
- Requester rule: a valid observed in the cycle after its ready is a new request.
- m_ready while IDLE: ignored, no ready is generated, err←1 (sticky until rst).
- A request arriving during BUSY waits. When the current transaction ends, it is considered in IDLE, and with RR=1 it wins over the port just served.

## Timing
- Reset (async, immediate):
  - state=IDLE; m_valid=0; m_addr=0; m_wdata=0; m_wstrb=0.
  - grant=0; last_grant=1, so port 0 wins the first tie.
  - busy=0; err=0; s0_ready=s1_ready=0.
- Latency:
  - A valid sampled in IDLE at edge k gives m_valid=1 from cycle k+1.
  - A zero-wait memory (m_ready in the first m_valid cycle) gives sN_ready in cycle k+1.
  - Minimum period is 2 cycles per transaction (IDLE + BUSY).
- m_valid stays high continuously until the cycle m_ready=1, inclusive, then drops.
- busy=1 exactly while state=BUSY.
- rst during BUSY aborts the transaction: no sN_ready is produced. Requesters reissue after reset.
- Memory read data is not registered; s_rdata has a combinational path from m_rdata.

## Test plan
- Single read, zero-wait memory: s0_valid=1, s0_addr=0x100, s0_wstrb=0.
  - Required: m_valid=1, m_addr=0x100 one cycle later.
  - m_ready=1 with m_rdata=0xDEADBEEF gives s0_ready=1, s0_rdata=0xDEADBEEF in that cycle; s1_ready=0.
- Write with 3 wait states: s1_valid=1, s1_addr=0x204, s1_wdata=0x12345678, s1_wstrb=0xF.
  - Required: m_valid held high 4 cycles with stable m_addr, m_wdata, m_wstrb.
  - s1_ready pulses once, in the cycle m_ready=1.
- Round-robin, both ports requesting continuously, RR=1, memory zero-wait:
  - After reset, the grant order is 0,1,0,1.
  - Each port receives one ready per 4 cycles.
- Fixed priority, RR=0, both ports requesting continuously:
  - Port 0 is served every 2 cycles and s1_ready never asserts.
  - After s0_valid drops, port 1 is served next.
- Input change during BUSY: change s0_addr from 0x100 to 0x300 while BUSY.
  - Required: m_addr stays 0x100 until the transaction completes.
- Spurious and abort cases:
  - m_ready pulse in IDLE: err=1 and stays 1; no sN_ready.
  - rst asserted mid-BUSY: m_valid=0, busy=0, err=0 immediately; no ready pulse.
